// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the multi-cycle memory responder.
package mem_resp_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2
    } state_t;

    // Legal range of the request-to-first-beat latency and the counter
    // width that covers it.
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;
    localparam int LAT_CNT_W   = 4;

    // Width of the beat offset inside an aligned burst block.
    function automatic int beat_off_w(input int burst_len);
        return $clog2(burst_len);
    endfunction

endpackage

// File: rtl/mem_array_sp.sv
// Single-port synchronous RAM with a one-cycle registered read port.
module mem_array_sp #(
    parameter int DEPTH_LOG2 = 15,
    parameter int DATA_W     = 16,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];
    logic [DATA_W-1:0] rdata_reg;

    // Write port and registered read; contents are never cleared by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_reg <= mem[addr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/mem_resp_ctrl.sv
// Memory responder: accepts one request at a time, returns single-word or
// critical-word-first wrapped burst responses after a fixed latency.
module mem_resp_ctrl
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 15,
    parameter int LATENCY    = 4,
    parameter int BURST_LEN  = 8,
    parameter     INIT_FILE  = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic              req_burst,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_last,
    output logic              busy
);

    // Out-of-range latencies are clamped into the supported window.
    localparam int LAT_C    = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                              (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
    localparam int LAT_LOAD = (LAT_C > 1) ? LAT_C - 2 : 0;
    localparam int OFF_W    = beat_off_w(BURST_LEN);

    state_t                 state_reg;
    logic                   req_ready_reg;
    logic                   busy_reg;
    logic                   rsp_valid_reg;
    logic                   rsp_last_reg;
    logic [ADDR_W-1:0]      rsp_addr_reg;
    logic [LAT_CNT_W-1:0]   lat_cnt_reg;
    logic [OFF_W-1:0]       beat_cnt_reg;
    logic                   wr_reg;
    logic                   burst_reg;
    logic [DEPTH_LOG2-1:0]  start_word_reg;
    logic [DATA_W-1:0]      wdata_reg;

    logic [DEPTH_LOG2-1:0]  req_word;
    logic [OFF_W-1:0]       beat_nxt;
    logic [DEPTH_LOG2-1:0]  beat_word;
    logic [DEPTH_LOG2-1:0]  mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [DATA_W-1:0]      mem_rdata;
    logic                   mem_we;

    // Byte address bit 0 carries no information for word storage.
    logic unused_addr_lsb;
    assign unused_addr_lsb = req_addr[0];

    assign req_word = req_addr[DEPTH_LOG2:1];
    assign beat_nxt = beat_cnt_reg + 1'b1;
    // Next beat wraps inside the aligned block: block base kept, offset advanced.
    assign beat_word = {start_word_reg[DEPTH_LOG2-1:OFF_W],
                        start_word_reg[OFF_W-1:0] + beat_nxt};

    // Storage is updated in the cycle just before the ack beat; a reset in
    // that cycle drops the write.
    assign mem_we = ~rst & (((state_reg == IDLE) && req_valid && req_wr && (LAT_C == 1)) ||
                            ((state_reg == WAIT) && (lat_cnt_reg == '0) && wr_reg));

    // RAM address always points at the word needed for the following beat.
    always_comb begin
        mem_addr  = start_word_reg;
        mem_wdata = wdata_reg;
        case (state_reg)
            IDLE: begin
                mem_addr  = req_word;
                mem_wdata = req_wdata;
            end
            WAIT:    mem_addr = start_word_reg;
            XFER:    mem_addr = beat_word;
            default: mem_addr = start_word_reg;
        endcase
    end

    mem_array_sp #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W),
        .INIT_FILE  (INIT_FILE)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Request/response FSM with registered handshake and beat outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            req_ready_reg  <= 1'b1;
            busy_reg       <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_last_reg   <= 1'b0;
            rsp_addr_reg   <= '0;
            lat_cnt_reg    <= '0;
            beat_cnt_reg   <= '0;
            wr_reg         <= 1'b0;
            burst_reg      <= 1'b0;
            start_word_reg <= '0;
            wdata_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        wr_reg         <= req_wr;
                        burst_reg      <= req_burst & ~req_wr;
                        start_word_reg <= req_word;
                        wdata_reg      <= req_wdata;
                        beat_cnt_reg   <= '0;
                        req_ready_reg  <= 1'b0;
                        busy_reg       <= 1'b1;
                        if (LAT_C == 1) begin
                            state_reg     <= XFER;
                            rsp_valid_reg <= 1'b1;
                            rsp_last_reg  <= ~(req_burst & ~req_wr);
                            rsp_addr_reg  <= ADDR_W'({req_word, 1'b0});
                        end else begin
                            state_reg   <= WAIT;
                            lat_cnt_reg <= LAT_CNT_W'(LAT_LOAD);
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt_reg == '0) begin
                        state_reg     <= XFER;
                        rsp_valid_reg <= 1'b1;
                        rsp_last_reg  <= ~burst_reg;
                        rsp_addr_reg  <= ADDR_W'({start_word_reg, 1'b0});
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 1'b1;
                    end
                end
                XFER: begin
                    if (rsp_last_reg) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                        rsp_last_reg  <= 1'b0;
                        rsp_addr_reg  <= '0;
                        busy_reg      <= 1'b0;
                        req_ready_reg <= 1'b1;
                        beat_cnt_reg  <= '0;
                    end else begin
                        beat_cnt_reg <= beat_nxt;
                        rsp_last_reg <= (beat_nxt == OFF_W'(BURST_LEN - 1));
                        rsp_addr_reg <= ADDR_W'({beat_word, 1'b0});
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_reg;
    assign busy      = busy_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_last  = rsp_last_reg;
    assign rsp_addr  = rsp_addr_reg;
    // Writes echo their data; reads return the registered RAM output.
    assign rsp_data  = rsp_valid_reg ? (wr_reg ? wdata_reg : mem_rdata) : '0;

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Directed bench for mem_resp_ctrl (LATENCY=4 instance plus a LATENCY=1 instance).
module tb_mem_resp_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid, req_wr, req_burst;
    logic [15:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_last, busy;
    logic [15:0] rsp_data, rsp_addr;

    logic        l1_valid, l1_wr, l1_burst;
    logic [15:0] l1_addr, l1_wdata;
    logic        l1_ready, l1_rsp_valid, l1_rsp_last, l1_busy;
    logic [15:0] l1_rsp_data, l1_rsp_addr;

    int vectors;
    int miscompares;
    logic [15:0] cwf_exp [0:7];

    mem_resp_ctrl #(.LATENCY(4)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_burst(req_burst), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
        .rsp_last(rsp_last), .busy(busy)
    );

    mem_resp_ctrl #(.LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(l1_valid), .req_ready(l1_ready), .req_wr(l1_wr),
        .req_burst(l1_burst), .req_addr(l1_addr), .req_wdata(l1_wdata),
        .rsp_valid(l1_rsp_valid), .rsp_data(l1_rsp_data), .rsp_addr(l1_rsp_addr),
        .rsp_last(l1_rsp_last), .busy(l1_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: req_ready=%b still not 1 after %0d cycles", req_ready, n);
        end
    endtask

    // Single write on the LATENCY=4 instance, ends in the cycle after the ack.
    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        wait_idle();
        req_valid = 1'b1; req_wr = 1'b1; req_burst = 1'b0; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0; req_wr = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        vectors++;
        if ({req_ready, busy, rsp_valid, rsp_last} !== 4'b1000 || rsp_data !== 16'h0 || rsp_addr !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_l4: ready/busy/valid/last=%b data=%h addr=%h, expected 1000 0000 0000",
                     {req_ready, busy, rsp_valid, rsp_last}, rsp_data, rsp_addr);
        end
        vectors++;
        if ({l1_ready, l1_busy, l1_rsp_valid, l1_rsp_last} !== 4'b1000 || l1_rsp_data !== 16'h0 || l1_rsp_addr !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_l1: ready/busy/valid/last=%b data=%h addr=%h, expected 1000 0000 0000",
                     {l1_ready, l1_busy, l1_rsp_valid, l1_rsp_last}, l1_rsp_data, l1_rsp_addr);
        end
    endtask

    task automatic test_single_read();
        wait_idle();
        req_valid = 1'b1; req_wr = 1'b0; req_burst = 1'b0; req_addr = 16'h0020;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_read accept: req_ready=%b expected 1", req_ready);
        end
        tick();                                   // T+1
        req_valid = 1'b0;
        vectors++;
        if ({rsp_valid, busy, req_ready} !== 3'b010) begin
            miscompares++;
            $display("FAIL single_read T+1: valid/busy/ready=%b expected 010", {rsp_valid, busy, req_ready});
        end
        tick(); tick();                           // T+3
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_read early beat: rsp_valid=%b at T+3 expected 0", rsp_valid);
        end
        tick();                                   // T+4
        vectors++;
        if ({rsp_valid, rsp_last} !== 2'b11 || rsp_data !== 16'hBEEF || rsp_addr !== 16'h0020) begin
            miscompares++;
            $display("FAIL single_read beat: valid/last=%b data=%h addr=%h expected 11 beef 0020",
                     {rsp_valid, rsp_last}, rsp_data, rsp_addr);
        end
        tick();                                   // T+5
        vectors++;
        if ({req_ready, busy, rsp_valid} !== 3'b100 || rsp_data !== 16'h0) begin
            miscompares++;
            $display("FAIL single_read T+5: ready/busy/valid=%b data=%h expected 100 0000",
                     {req_ready, busy, rsp_valid}, rsp_data);
        end
    endtask

    task automatic test_write_read();
        wait_idle();
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0042; req_wdata = 16'h1234;
        tick();
        req_valid = 1'b0; req_wr = 1'b0; req_wdata = 16'h0;
        repeat (3) tick();                        // T+4
        vectors++;
        if ({rsp_valid, rsp_last} !== 2'b11 || rsp_data !== 16'h1234 || rsp_addr !== 16'h0042) begin
            miscompares++;
            $display("FAIL write_ack: valid/last=%b data=%h addr=%h expected 11 1234 0042",
                     {rsp_valid, rsp_last}, rsp_data, rsp_addr);
        end
        tick();
        req_valid = 1'b1; req_addr = 16'h0043;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL write_read ready: req_ready=%b expected 1 after ack", req_ready);
        end
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({rsp_valid, rsp_last} !== 2'b11 || rsp_data !== 16'h1234 || rsp_addr !== 16'h0042) begin
            miscompares++;
            $display("FAIL read_after_write: valid/last=%b data=%h addr=%h expected 11 1234 0042",
                     {rsp_valid, rsp_last}, rsp_data, rsp_addr);
        end
        tick();
    endtask

    task automatic test_burst();
        cwf_exp = '{16'd5, 16'd6, 16'd7, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4};
        wait_idle();
        req_valid = 1'b1; req_burst = 1'b1; req_addr = 16'h000A;
        tick();
        req_valid = 1'b0; req_burst = 1'b0;
        repeat (3) tick();                        // T+4
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if ({rsp_valid, busy, req_ready, rsp_last} !== {3'b110, (k == 7)} ||
                rsp_data !== cwf_exp[k] || rsp_addr !== {cwf_exp[k][14:0], 1'b0}) begin
                miscompares++;
                $display("FAIL burst beat %0d: valid/busy/ready/last=%b data=%h addr=%h expected %b %h %h",
                         k, {rsp_valid, busy, req_ready, rsp_last}, rsp_data, rsp_addr,
                         {3'b110, (k == 7)}, cwf_exp[k], {cwf_exp[k][14:0], 1'b0});
            end
            tick();
        end
        vectors++;                                // T+12
        if ({rsp_valid, req_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL burst end: valid/ready=%b expected 01", {rsp_valid, req_ready});
        end
    endtask

    task automatic test_back_pressure();
        wait_idle();
        req_valid = 1'b1; req_burst = 1'b1; req_addr = 16'h0000;
        tick();                                   // T+1
        req_burst = 1'b0; req_addr = 16'h0020;    // second request held
        for (int c = 1; c < 12; c++) begin
            vectors++;
            if ({req_ready, busy} !== 2'b01 || (c >= 4 && (rsp_valid !== 1'b1 || rsp_data !== 16'(c - 4)))) begin
                miscompares++;
                $display("FAIL back_pressure T+%0d: ready/busy=%b valid=%b data=%h expected 01 beat %0d",
                         c, {req_ready, busy}, rsp_valid, rsp_data, c - 4);
            end
            tick();
        end
        vectors++;                                // T+12
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL back_pressure accept: req_ready=%b at T+12 expected 1", req_ready);
        end
        tick();                                   // T+13
        req_valid = 1'b0;
        vectors++;
        if ({req_ready, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL back_pressure second busy: ready/busy=%b expected 01", {req_ready, busy});
        end
        repeat (3) tick();                        // T+16
        vectors++;
        if ({rsp_valid, rsp_last} !== 2'b11 || rsp_data !== 16'hBEEF || rsp_addr !== 16'h0020) begin
            miscompares++;
            $display("FAIL back_pressure second data: valid/last=%b data=%h addr=%h expected 11 beef 0020",
                     {rsp_valid, rsp_last}, rsp_data, rsp_addr);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        logic seen;
        wait_idle();
        req_valid = 1'b1; req_burst = 1'b1; req_addr = 16'h0000;
        tick();
        req_valid = 1'b0; req_burst = 1'b0;
        repeat (5) tick();                        // T+6
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h0002) begin
            miscompares++;
            $display("FAIL reset_mid pre: valid=%b data=%h expected 1 0002", rsp_valid, rsp_data);
        end
        rst = 1'b1;
        tick();                                   // T+7
        rst = 1'b0;
        vectors++;
        if ({rsp_valid, busy, req_ready, rsp_last} !== 4'b0010 || rsp_data !== 16'h0 || rsp_addr !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_mid T+7: valid/busy/ready/last=%b data=%h addr=%h expected 0010 0000 0000",
                     {rsp_valid, busy, req_ready, rsp_last}, rsp_data, rsp_addr);
        end
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid stray beat: rsp_valid seen=%b expected 0", seen);
        end
        // reset together with a request: must not be accepted
        rst = 1'b1; req_valid = 1'b1; req_addr = 16'h0020;
        tick();
        rst = 1'b0; req_valid = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            tick();
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_with_req: activity seen=%b expected 0", seen);
        end
        // storage survives reset
        req_valid = 1'b1; req_addr = 16'h0006;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({rsp_valid, rsp_last} !== 2'b11 || rsp_data !== 16'h0003 || rsp_addr !== 16'h0006) begin
            miscompares++;
            $display("FAIL reset_mid reread: valid/last=%b data=%h addr=%h expected 11 0003 0006",
                     {rsp_valid, rsp_last}, rsp_data, rsp_addr);
        end
        tick();
    endtask

    task automatic test_latency1();
        // preload word 1 = 1111, word 2 = 2222; ack one cycle after accept
        l1_valid = 1'b1; l1_wr = 1'b1; l1_addr = 16'h0002; l1_wdata = 16'h1111;
        tick();
        vectors++;
        if ({l1_rsp_valid, l1_rsp_last} !== 2'b11 || l1_rsp_data !== 16'h1111) begin
            miscompares++;
            $display("FAIL lat1 write ack: valid/last=%b data=%h expected 11 1111",
                     {l1_rsp_valid, l1_rsp_last}, l1_rsp_data);
        end
        l1_valid = 1'b0;
        tick();
        l1_valid = 1'b1; l1_addr = 16'h0004; l1_wdata = 16'h2222;
        tick();
        l1_valid = 1'b0; l1_wr = 1'b0;
        tick();
        // back-to-back reads with req_valid held high
        l1_valid = 1'b1; l1_addr = 16'h0003;
        vectors++;
        if (l1_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL lat1 ready: req_ready=%b expected 1", l1_ready);
        end
        tick();                                   // T+1
        vectors++;
        if ({l1_rsp_valid, l1_ready, l1_busy} !== 3'b101 || l1_rsp_data !== 16'h1111 || l1_rsp_addr !== 16'h0002) begin
            miscompares++;
            $display("FAIL lat1 read1: valid/ready/busy=%b data=%h addr=%h expected 101 1111 0002",
                     {l1_rsp_valid, l1_ready, l1_busy}, l1_rsp_data, l1_rsp_addr);
        end
        l1_addr = 16'h0004;
        tick();                                   // T+2
        vectors++;
        if ({l1_rsp_valid, l1_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL lat1 re-accept: valid/ready=%b expected 01", {l1_rsp_valid, l1_ready});
        end
        tick();                                   // T+3
        l1_valid = 1'b0;
        vectors++;
        if ({l1_rsp_valid, l1_rsp_last} !== 2'b11 || l1_rsp_data !== 16'h2222 || l1_rsp_addr !== 16'h0004) begin
            miscompares++;
            $display("FAIL lat1 read2: valid/last=%b data=%h addr=%h expected 11 2222 0004",
                     {l1_rsp_valid, l1_rsp_last}, l1_rsp_data, l1_rsp_addr);
        end
        tick();
        vectors++;
        if ({l1_ready, l1_busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL lat1 idle: ready/busy=%b expected 10", {l1_ready, l1_busy});
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_burst = 1'b0; req_addr = '0; req_wdata = '0;
        l1_valid = 1'b0; l1_wr = 1'b0; l1_burst = 1'b0; l1_addr = '0; l1_wdata = '0;
        repeat (3) tick();
        test_reset();
        rst = 1'b0;
        tick();
        do_write(16'h0020, 16'hBEEF);
        for (int i = 0; i < 8; i++) begin
            do_write(16'(2 * i), 16'(i));
        end
        test_single_read();
        test_write_read();
        test_burst();
        test_back_pressure();
        test_reset_mid_burst();
        test_latency1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
